// File: rtl/crossing_pkg.sv
// Shared state encoding, lamp bundle and default phase durations for the crossing scheduler.
// Defining CROSSING_PED_FLASH_EN adds the PED_FLASH state.
package crossing_pkg;

    localparam int DEF_TIMER_SCALE  = 16000000;
    localparam int DEF_T_MIN_GREEN  = 10;
    localparam int DEF_T_YELLOW     = 3;
    localparam int DEF_T_ALLRED     = 2;
    localparam int DEF_T_SIDE_GREEN = 8;
    localparam int DEF_T_WALK       = 6;
    localparam int DEF_T_FLASH      = 4;

    typedef enum logic [2:0] {
        ST_MAIN_GREEN  = 3'd0,
        ST_MAIN_YELLOW = 3'd1,
        ST_CLEAR_IN    = 3'd2,
        ST_SIDE_GREEN  = 3'd3,
        ST_SIDE_YELLOW = 3'd4,
        ST_PED_WALK    = 3'd5,
        ST_CLEAR_OUT   = 3'd6
`ifdef CROSSING_PED_FLASH_EN
        ,
        ST_PED_FLASH   = 3'd7
`endif
    } state_t;

    typedef enum logic {
        SERVED_SIDE = 1'b0,
        SERVED_PED  = 1'b1
    } served_t;

    typedef struct packed {
        logic green;
        logic yellow;
        logic red;
        logic side_green;
        logic side_yellow;
        logic side_red;
        logic ped_green;
        logic ped_red;
    } lamps_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Every road shows red unless its own phase is active.
    function automatic lamps_t lamps_for(input state_t s);
        lamps_t l;
        l          = '0;
        l.red      = 1'b1;
        l.side_red = 1'b1;
        l.ped_red  = 1'b1;
        case (s)
            ST_MAIN_GREEN: begin
                l.green = 1'b1;
                l.red   = 1'b0;
            end
            ST_MAIN_YELLOW: begin
                l.yellow = 1'b1;
                l.red    = 1'b0;
            end
            ST_SIDE_GREEN: begin
                l.side_green = 1'b1;
                l.side_red   = 1'b0;
            end
            ST_SIDE_YELLOW: begin
                l.side_yellow = 1'b1;
                l.side_red    = 1'b0;
            end
            ST_PED_WALK: begin
                l.ped_green = 1'b1;
                l.ped_red   = 1'b0;
            end
`ifdef CROSSING_PED_FLASH_EN
            ST_PED_FLASH: begin
                l.ped_red = 1'b0;
            end
`endif
            default: ;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Restartable clock divider: a one-cycle tick on the last cycle of every TIMER_SCALE-cycle period.
module tick_prescaler import crossing_pkg::*; #(
    parameter int TIMER_SCALE = DEF_TIMER_SCALE
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (TIMER_SCALE > 1) ? $clog2(TIMER_SCALE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMER_SCALE - 1);

    logic [CNT_W-1:0] count;

    assign tick = (count == LAST);

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // register samples the pre-edge values of the others regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst || clear || tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/crossing_scheduler.sv
// Main road / side road / pedestrian crossing controller with latched requests and fair arbitration.
// Defining CROSSING_PED_FLASH_EN inserts a flashing pedestrian phase after the walk phase.
module crossing_scheduler import crossing_pkg::*; #(
    parameter int TIMER_SCALE  = DEF_TIMER_SCALE,
    parameter int T_MIN_GREEN  = DEF_T_MIN_GREEN,
    parameter int T_YELLOW     = DEF_T_YELLOW,
    parameter int T_ALLRED     = DEF_T_ALLRED,
    parameter int T_SIDE_GREEN = DEF_T_SIDE_GREEN,
    parameter int T_WALK       = DEF_T_WALK,
    parameter int T_FLASH      = DEF_T_FLASH
) (
    input  logic pin3_clk_16mhz,
    input  logic pin2_rst,
    input  logic pin9_side_sensor,
    input  logic pin10_ped_button,
    output logic pin4_green,
    output logic pin5_yellow,
    output logic pin6_red,
    output logic pin7_ped_green,
    output logic pin8_ped_red,
    output logic pin11_side_green,
    output logic pin12_side_yellow,
    output logic pin13_side_red
);

    // T_FLASH takes part in sizing only, so the timer width is the same in both builds.
    localparam int T_MAX = max_int(max_int(max_int(T_MIN_GREEN, T_YELLOW),
                                           max_int(T_ALLRED, T_SIDE_GREEN)),
                                   max_int(T_WALK, T_FLASH));
    localparam int TIMER_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    typedef logic [TIMER_W-1:0] timer_t;

    function automatic timer_t load_for(input state_t s);
        int d;
        case (s)
            ST_MAIN_GREEN:  d = T_MIN_GREEN;
            ST_MAIN_YELLOW: d = T_YELLOW;
            ST_CLEAR_IN:    d = T_ALLRED;
            ST_SIDE_GREEN:  d = T_SIDE_GREEN;
            ST_SIDE_YELLOW: d = T_YELLOW;
            ST_PED_WALK:    d = T_WALK;
            ST_CLEAR_OUT:   d = T_ALLRED;
`ifdef CROSSING_PED_FLASH_EN
            ST_PED_FLASH:   d = T_FLASH;
`endif
            default:        d = T_MIN_GREEN;
        endcase
        return timer_t'(d - 1);
    endfunction

    state_t  state;
    state_t  next_state;
    served_t last_served;
    timer_t  timer;
    lamps_t  lamps;
    logic    min_met;
    logic    side_req;
    logic    ped_req;
    logic    tick;
    logic    timer_done;
    logic    leave;

    tick_prescaler #(
        .TIMER_SCALE(TIMER_SCALE)
    ) u_prescaler (
        .clk  (pin3_clk_16mhz),
        .rst  (pin2_rst),
        .clear(leave),
        .tick (tick)
    );

    assign timer_done = tick && (timer == '0);

    // Main green may only be left once its minimum has elapsed and someone is waiting.
    assign leave = (state == ST_MAIN_GREEN) ? ((min_met || timer_done) && (side_req || ped_req))
                                            : timer_done;

    // NOTE: next_state gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            ST_MAIN_GREEN:  next_state = ST_MAIN_YELLOW;
            ST_MAIN_YELLOW: next_state = ST_CLEAR_IN;
            ST_CLEAR_IN: begin
                if (side_req && ped_req) begin
                    next_state = (last_served == SERVED_SIDE) ? ST_PED_WALK : ST_SIDE_GREEN;
                end else if (side_req) begin
                    next_state = ST_SIDE_GREEN;
                end else begin
                    next_state = ST_PED_WALK;
                end
            end
            ST_SIDE_GREEN:  next_state = ST_SIDE_YELLOW;
            ST_SIDE_YELLOW: next_state = ST_CLEAR_OUT;
`ifdef CROSSING_PED_FLASH_EN
            ST_PED_WALK:    next_state = ST_PED_FLASH;
            ST_PED_FLASH:   next_state = ST_CLEAR_OUT;
`else
            ST_PED_WALK:    next_state = ST_CLEAR_OUT;
`endif
            ST_CLEAR_OUT:   next_state = ST_MAIN_GREEN;
            default:        next_state = ST_MAIN_GREEN;
        endcase
    end

    always_ff @(posedge pin3_clk_16mhz) begin
        if (pin2_rst) begin
            state       <= ST_MAIN_GREEN;
            timer       <= load_for(ST_MAIN_GREEN);
            min_met     <= 1'b0;
            side_req    <= 1'b0;
            ped_req     <= 1'b0;
            last_served <= SERVED_SIDE;
            lamps       <= lamps_for(ST_MAIN_GREEN);
        end else begin
            // A request still asserted on the entry cycle of its own phase stays latched.
            side_req <= pin9_side_sensor | (side_req & !(leave && next_state == ST_SIDE_GREEN));
            ped_req  <= pin10_ped_button | (ped_req & !(leave && next_state == ST_PED_WALK));

            if (leave) begin
                state   <= next_state;
                timer   <= load_for(next_state);
                min_met <= 1'b0;
                lamps   <= lamps_for(next_state);
                if (next_state == ST_SIDE_GREEN) begin
                    last_served <= SERVED_SIDE;
                end else if (next_state == ST_PED_WALK) begin
                    last_served <= SERVED_PED;
                end
            end else if (tick) begin
                if (timer != '0) begin
                    timer <= timer - 1'b1;
                end else if (state == ST_MAIN_GREEN) begin
                    min_met <= 1'b1;
                end
`ifdef CROSSING_PED_FLASH_EN
                if (state == ST_PED_FLASH) begin
                    lamps.ped_green <= ~lamps.ped_green;
                end
`endif
            end
        end
    end

    assign pin4_green        = lamps.green;
    assign pin5_yellow       = lamps.yellow;
    assign pin6_red          = lamps.red;
    assign pin11_side_green  = lamps.side_green;
    assign pin12_side_yellow = lamps.side_yellow;
    assign pin13_side_red    = lamps.side_red;
    assign pin7_ped_green    = lamps.ped_green;
    assign pin8_ped_red      = lamps.ped_red;

endmodule

// File: tb/tb_crossing_scheduler.sv
// Self-checking bench for crossing_scheduler: timing tables, corner sequences and a random run
// against a cycle-level phase model.
module tb_crossing_scheduler;

    localparam int S = 1;
`ifdef CROSSING_PED_FLASH_EN
    localparam int FLASH_CYC = 4;
`else
    localparam int FLASH_CYC = 0;
`endif

    // Lamp vector order: green yellow red | side_green side_yellow side_red | ped_green ped_red
    localparam logic [7:0] L_MG     = 8'b100_001_01;
    localparam logic [7:0] L_MY     = 8'b010_001_01;
    localparam logic [7:0] L_ALLRED = 8'b001_001_01;
    localparam logic [7:0] L_SG     = 8'b001_100_01;
    localparam logic [7:0] L_SY     = 8'b001_010_01;
    localparam logic [7:0] L_PW     = 8'b001_001_10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic side = 1'b0;
    logic ped = 1'b0;
    logic rst_b = 1'b1;
    logic side_b = 1'b0;

    logic green, yellow, red, side_green, side_yellow, side_red, ped_green, ped_red;
    logic green_b, yellow_b, red_b, side_green_b, side_yellow_b, side_red_b, ped_green_b, ped_red_b;
    logic [7:0] lamps_a;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    crossing_scheduler #(.TIMER_SCALE(S)) dut (
        .pin3_clk_16mhz   (clk),
        .pin2_rst         (rst),
        .pin9_side_sensor (side),
        .pin10_ped_button (ped),
        .pin4_green       (green),
        .pin5_yellow      (yellow),
        .pin6_red         (red),
        .pin7_ped_green   (ped_green),
        .pin8_ped_red     (ped_red),
        .pin11_side_green (side_green),
        .pin12_side_yellow(side_yellow),
        .pin13_side_red   (side_red)
    );

    crossing_scheduler #(.TIMER_SCALE(4)) dut_b (
        .pin3_clk_16mhz   (clk),
        .pin2_rst         (rst_b),
        .pin9_side_sensor (side_b),
        .pin10_ped_button (1'b0),
        .pin4_green       (green_b),
        .pin5_yellow      (yellow_b),
        .pin6_red         (red_b),
        .pin7_ped_green   (ped_green_b),
        .pin8_ped_red     (ped_red_b),
        .pin11_side_green (side_green_b),
        .pin12_side_yellow(side_yellow_b),
        .pin13_side_red   (side_red_b)
    );

    assign lamps_a = {green, yellow, red, side_green, side_yellow, side_red, ped_green, ped_red};

    // ---------------- reference model: phases measured in clock cycles ----------------
    typedef enum int {P_MG, P_MY, P_CI, P_SG, P_SY, P_PW, P_PF, P_CO} phase_e;

    phase_e m_ph = P_MG;
    int     m_el = 0;
    bit     m_sreq = 1'b0;
    bit     m_preq = 1'b0;
    bit     m_last_side = 1'b1;

    function automatic int dur(input phase_e p);
        case (p)
            P_MG:    return 10;
            P_MY:    return 3;
            P_CI:    return 2;
            P_SG:    return 8;
            P_SY:    return 3;
            P_PW:    return 6;
            P_PF:    return 4;
            default: return 2;
        endcase
    endfunction

    function automatic logic [7:0] model_lamps();
        case (m_ph)
            P_MG:    return L_MG;
            P_MY:    return L_MY;
            P_SG:    return L_SG;
            P_SY:    return L_SY;
            P_PW:    return L_PW;
            P_PF:    return {6'b001_001, ((m_el / S) % 2) == 1, 1'b0};
            default: return L_ALLRED;
        endcase
    endfunction

    function automatic void model_step(input logic r, input logic s, input logic p);
        bit     go;
        phase_e nxt;
        if (r) begin
            m_ph = P_MG; m_el = 0; m_sreq = 1'b0; m_preq = 1'b0; m_last_side = 1'b1;
            return;
        end
        if (m_ph == P_MG) go = (m_el + 1 >= 10 * S) && (m_sreq || m_preq);
        else              go = (m_el + 1 == dur(m_ph) * S);
        case (m_ph)
            P_MG:    nxt = P_MY;
            P_MY:    nxt = P_CI;
            P_CI:    nxt = (m_sreq && (!m_preq || !m_last_side)) ? P_SG : P_PW;
            P_SG:    nxt = P_SY;
            P_SY:    nxt = P_CO;
            P_PW:    nxt = (FLASH_CYC > 0) ? P_PF : P_CO;
            P_PF:    nxt = P_CO;
            default: nxt = P_MG;
        endcase
        m_sreq = s || (m_sreq && !(go && nxt == P_SG));
        m_preq = p || (m_preq && !(go && nxt == P_PW));
        if (go) begin
            if (nxt == P_SG) m_last_side = 1'b1;
            if (nxt == P_PW) m_last_side = 1'b0;
            m_ph = nxt;
            m_el = 0;
        end else begin
            m_el++;
        end
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %b, expected %b", name, $time, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, got, exp);
        end
    endtask

    // Advance one clock: the model consumes the inputs of the ending cycle, then both are compared.
    task automatic tick_cycle();
        model_step(rst, side, ped);
        @(posedge clk);
        #1;
        check8("model", lamps_a, model_lamps());
    endtask

    task automatic do_reset();
        rst = 1'b1; side = 1'b0; ped = 1'b0;
        tick_cycle();
        rst = 1'b0;
    endtask

    typedef struct {
        int         first;
        int         last;
        logic       side;
        logic       ped;
        logic [7:0] lamps;
    } seg_t;

    seg_t segs[9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_pw, first_mg_back, first_sg, first_y, end_y;

        segs[0] = '{0,  1,  1'b0, 1'b0, L_MG};
        segs[1] = '{2,  2,  1'b1, 1'b0, L_MG};
        segs[2] = '{3,  9,  1'b0, 1'b0, L_MG};
        segs[3] = '{10, 12, 1'b0, 1'b0, L_MY};
        segs[4] = '{13, 14, 1'b0, 1'b0, L_ALLRED};
        segs[5] = '{15, 22, 1'b0, 1'b0, L_SG};
        segs[6] = '{23, 25, 1'b0, 1'b0, L_SY};
        segs[7] = '{26, 27, 1'b0, 1'b0, L_ALLRED};
        segs[8] = '{28, 40, 1'b0, 1'b0, L_MG};

        // Reset values, then a long idle stretch with no requests.
        do_reset();
        check8("reset_vals", lamps_a, L_MG);
        for (int c = 0; c < 200; c++) begin
            check8("idle_main_green", lamps_a, L_MG);
            tick_cycle();
        end

        // Side request pulsed at cycle 2: full side cycle timeline.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            for (int c = segs[i].first; c <= segs[i].last; c++) begin
                side = segs[i].side;
                ped  = segs[i].ped;
                check8("side_timeline", lamps_a, segs[i].lamps);
                tick_cycle();
            end
        end
        side = 1'b0; ped = 1'b0;

        // Both requests at cycle 2: pedestrian first, side served on the following round.
        do_reset();
        first_pw = -1; first_mg_back = -1; first_sg = -1;
        for (int c = 0; c <= 60; c++) begin
            side = (c == 2);
            ped  = (c == 2);
            if (first_pw < 0 && lamps_a == L_PW) first_pw = c;
            if (first_pw >= 0 && first_mg_back < 0 && green) first_mg_back = c;
            if (first_sg < 0 && side_green) first_sg = c;
            tick_cycle();
        end
        side = 1'b0; ped = 1'b0;
        check_int("both_ped_first", first_pw, 15);
        check_int("both_main_back", first_mg_back, 23 + FLASH_CYC);
        check_int("both_side_next", first_sg, 38 + FLASH_CYC);

        // Reset in the middle of side green discards the pending pedestrian request.
        do_reset();
        for (int c = 0; c < 17; c++) begin
            side = (c == 2);
            ped  = (c == 16);
            tick_cycle();
        end
        check8("in_side_green", lamps_a, L_SG);
        rst = 1'b1; side = 1'b0; ped = 1'b1;
        tick_cycle();
        rst = 1'b0; ped = 1'b0;
        check8("mid_reset_vals", lamps_a, L_MG);
        for (int c = 0; c < 14; c++) begin
            check8("post_reset_hold", lamps_a, L_MG);
            tick_cycle();
        end

        // Randomised traffic with occasional resets and busy bursts.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            bit busy;
            busy = ((c / 500) % 2) == 1;
            rst  = ($urandom_range(0, 599) == 0);
            side = busy ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 39) == 0);
            ped  = busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 49) == 0);
            check_int("main_onehot", $countones(lamps_a[7:5]), 1);
            check_int("side_onehot", $countones(lamps_a[4:2]), 1);
            check_int("green_conflict", int'(green & (side_green | ped_green)), 0);
            tick_cycle();
        end
        rst = 1'b0; side = 1'b0; ped = 1'b0;

        // Prescaled instance: main yellow exactly 40 cycles after reset release.
        rst_b = 1'b1;
        tick_cycle();
        rst_b = 1'b0;
        check8("scaled_reset_vals",
               {green_b, yellow_b, red_b, side_green_b, side_yellow_b, side_red_b, ped_green_b, ped_red_b},
               L_MG);
        first_y = -1; end_y = -1;
        for (int c = 0; c < 200; c++) begin
            side_b = (c == 0);
            if (first_y < 0 && yellow_b) first_y = c;
            if (first_y >= 0 && end_y < 0 && !yellow_b) end_y = c;
            tick_cycle();
        end
        side_b = 1'b0;
        check_int("scaled_yellow_start", first_y, 40);
        check_int("scaled_yellow_end", end_y, 52);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
